// File: rtl/decode_stage.sv
// decode_stage: registered, handshaked RV32I decode for OP-IMM, OP, LOAD,
// STORE, LUI and AUIPC. Holds one decoded bundle, inserts a bubble on a
// load-use dependency, supports flush and counts hazard stall cycles.
module decode_stage #(
   parameter int XLEN    = 32,
   parameter int ALUOP_W = 4,
   parameter int CNT_W   = 16
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               flush,
   input  logic               in_valid,
   output logic               in_ready,
   input  logic [31:0]        in_inst,
   input  logic [XLEN-1:0]    in_pc,
   output logic               out_valid,
   input  logic               out_ready,
   output logic [XLEN-1:0]    out_pc,
   output logic [4:0]         out_rs1,
   output logic [4:0]         out_rs2,
   output logic [4:0]         out_rd,
   output logic [XLEN-1:0]    out_imm,
   output logic [ALUOP_W-1:0] out_alu_op,
   output logic               out_alu_src_imm,
   output logic               out_alu_src_pc,
   output logic [1:0]         out_mem_op,
   output logic [1:0]         out_mem_size,
   output logic               out_mem_unsigned,
   output logic               out_reg_we,
   output logic               out_illegal,
   output logic [CNT_W-1:0]   stall_cnt
);

   localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
   localparam logic [6:0] OPC_OP     = 7'b0110011;
   localparam logic [6:0] OPC_LOAD   = 7'b0000011;
   localparam logic [6:0] OPC_STORE  = 7'b0100011;
   localparam logic [6:0] OPC_LUI    = 7'b0110111;
   localparam logic [6:0] OPC_AUIPC  = 7'b0010111;

   localparam logic [6:0] F7_ZERO = 7'b0000000;
   localparam logic [6:0] F7_ALT  = 7'b0100000;

   localparam logic [ALUOP_W-1:0] ALU_NOP   = ALUOP_W'(0);
   localparam logic [ALUOP_W-1:0] ALU_ADD   = ALUOP_W'(1);
   localparam logic [ALUOP_W-1:0] ALU_SUB   = ALUOP_W'(2);
   localparam logic [ALUOP_W-1:0] ALU_SLL   = ALUOP_W'(3);
   localparam logic [ALUOP_W-1:0] ALU_SLT   = ALUOP_W'(4);
   localparam logic [ALUOP_W-1:0] ALU_SLTU  = ALUOP_W'(5);
   localparam logic [ALUOP_W-1:0] ALU_XOR   = ALUOP_W'(6);
   localparam logic [ALUOP_W-1:0] ALU_SRL   = ALUOP_W'(7);
   localparam logic [ALUOP_W-1:0] ALU_SRA   = ALUOP_W'(8);
   localparam logic [ALUOP_W-1:0] ALU_OR    = ALUOP_W'(9);
   localparam logic [ALUOP_W-1:0] ALU_AND   = ALUOP_W'(10);
   localparam logic [ALUOP_W-1:0] ALU_PASSB = ALUOP_W'(11);

   localparam logic [1:0] MEM_NOP   = 2'd0;
   localparam logic [1:0] MEM_READ  = 2'd1;
   localparam logic [1:0] MEM_WRITE = 2'd2;

   localparam logic [1:0] SIZE_BYTE = 2'd0;
   localparam logic [1:0] SIZE_HALF = 2'd1;
   localparam logic [1:0] SIZE_WORD = 2'd2;

   // instruction fields
   logic [6:0] opcode;
   logic [4:0] f_rd;
   logic [2:0] f3;
   logic [4:0] f_rs1;
   logic [4:0] f_rs2;
   logic [6:0] f7;

   assign opcode = in_inst[6:0];
   assign f_rd   = in_inst[11:7];
   assign f3     = in_inst[14:12];
   assign f_rs1  = in_inst[19:15];
   assign f_rs2  = in_inst[24:20];
   assign f7     = in_inst[31:25];

   // decoded (not yet registered) bundle
   logic [4:0]         d_rs1, d_rs2, d_rd;
   logic [XLEN-1:0]    d_imm;
   logic [ALUOP_W-1:0] d_alu;
   logic               d_simm, d_spc;
   logic [1:0]         d_mop, d_msz;
   logic               d_muns, d_we, d_ill;
   logic               use_rs1, use_rs2;
   logic               hazard;
   logic               accept;

   function automatic logic [XLEN-1:0] sext12(input logic [11:0] v);
      return XLEN'($signed(v));
   endfunction

   function automatic logic [XLEN-1:0] sext32(input logic [31:0] v);
      return XLEN'($signed(v));
   endfunction

   // Decode the incoming word; an undecodable word collapses to an all-zero bundle with illegal set
   always_comb begin
      d_rs1   = '0;
      d_rs2   = '0;
      d_rd    = '0;
      d_imm   = '0;
      d_alu   = ALU_NOP;
      d_simm  = 1'b0;
      d_spc   = 1'b0;
      d_mop   = MEM_NOP;
      d_msz   = SIZE_BYTE;
      d_muns  = 1'b0;
      d_we    = 1'b0;
      d_ill   = 1'b0;
      use_rs1 = 1'b0;
      use_rs2 = 1'b0;
      case (opcode)
         OPC_OP_IMM: begin
            d_rs1   = f_rs1;
            d_rd    = f_rd;
            d_imm   = sext12(in_inst[31:20]);
            d_simm  = 1'b1;
            d_we    = (f_rd != 5'd0);
            use_rs1 = 1'b1;
            case (f3)
               3'd0: d_alu = ALU_ADD;
               3'd2: d_alu = ALU_SLT;
               3'd3: d_alu = ALU_SLTU;
               3'd4: d_alu = ALU_XOR;
               3'd6: d_alu = ALU_OR;
               3'd7: d_alu = ALU_AND;
               3'd1: begin
                  d_imm = XLEN'(in_inst[24:20]);
                  if (f7 == F7_ZERO) d_alu = ALU_SLL;
                  else d_ill = 1'b1;
               end
               default: begin
                  d_imm = XLEN'(in_inst[24:20]);
                  if (f7 == F7_ZERO) d_alu = ALU_SRL;
                  else if (f7 == F7_ALT) d_alu = ALU_SRA;
                  else d_ill = 1'b1;
               end
            endcase
         end
         OPC_OP: begin
            d_rs1   = f_rs1;
            d_rs2   = f_rs2;
            d_rd    = f_rd;
            d_we    = (f_rd != 5'd0);
            use_rs1 = 1'b1;
            use_rs2 = 1'b1;
            if (f7 == F7_ZERO) begin
               case (f3)
                  3'd0:    d_alu = ALU_ADD;
                  3'd1:    d_alu = ALU_SLL;
                  3'd2:    d_alu = ALU_SLT;
                  3'd3:    d_alu = ALU_SLTU;
                  3'd4:    d_alu = ALU_XOR;
                  3'd5:    d_alu = ALU_SRL;
                  3'd6:    d_alu = ALU_OR;
                  default: d_alu = ALU_AND;
               endcase
            end else if (f7 == F7_ALT && f3 == 3'd0) begin
               d_alu = ALU_SUB;
            end else if (f7 == F7_ALT && f3 == 3'd5) begin
               d_alu = ALU_SRA;
            end else begin
               d_ill = 1'b1;
            end
         end
         OPC_LOAD: begin
            d_rs1   = f_rs1;
            d_rd    = f_rd;
            d_imm   = sext12(in_inst[31:20]);
            d_alu   = ALU_ADD;
            d_simm  = 1'b1;
            d_mop   = MEM_READ;
            d_we    = (f_rd != 5'd0);
            use_rs1 = 1'b1;
            case (f3)
               3'd0: d_msz = SIZE_BYTE;
               3'd1: d_msz = SIZE_HALF;
               3'd2: d_msz = SIZE_WORD;
               3'd4: begin
                  d_msz  = SIZE_BYTE;
                  d_muns = 1'b1;
               end
               3'd5: begin
                  d_msz  = SIZE_HALF;
                  d_muns = 1'b1;
               end
               default: d_ill = 1'b1;
            endcase
         end
         OPC_STORE: begin
            d_rs1   = f_rs1;
            d_rs2   = f_rs2;
            d_imm   = sext12({in_inst[31:25], in_inst[11:7]});
            d_alu   = ALU_ADD;
            d_simm  = 1'b1;
            d_mop   = MEM_WRITE;
            use_rs1 = 1'b1;
            use_rs2 = 1'b1;
            case (f3)
               3'd0:    d_msz = SIZE_BYTE;
               3'd1:    d_msz = SIZE_HALF;
               3'd2:    d_msz = SIZE_WORD;
               default: d_ill = 1'b1;
            endcase
         end
         OPC_LUI: begin
            d_rd   = f_rd;
            d_imm  = sext32({in_inst[31:12], 12'b0});
            d_alu  = ALU_PASSB;
            d_simm = 1'b1;
            d_we   = (f_rd != 5'd0);
         end
         OPC_AUIPC: begin
            d_rd   = f_rd;
            d_imm  = sext32({in_inst[31:12], 12'b0});
            d_alu  = ALU_ADD;
            d_simm = 1'b1;
            d_spc  = 1'b1;
            d_we   = (f_rd != 5'd0);
         end
         default: d_ill = 1'b1;
      endcase
      if (d_ill) begin
         d_rs1   = '0;
         d_rs2   = '0;
         d_rd    = '0;
         d_imm   = '0;
         d_alu   = ALU_NOP;
         d_simm  = 1'b0;
         d_spc   = 1'b0;
         d_mop   = MEM_NOP;
         d_msz   = SIZE_BYTE;
         d_muns  = 1'b0;
         d_we    = 1'b0;
         use_rs1 = 1'b0;
         use_rs2 = 1'b0;
      end
   end

   // A held load whose destination feeds the incoming instruction blocks it for one cycle
   always_comb begin
      hazard = in_valid && out_valid && (out_mem_op == MEM_READ) && (out_rd != 5'd0) &&
               ((use_rs1 && (d_rs1 == out_rd)) || (use_rs2 && (d_rs2 == out_rd)));
      in_ready = !flush && !hazard && (!out_valid || out_ready);
      accept   = in_valid && in_ready;
   end

   // Output register: flush kills, transfer loads, drained output becomes a bubble with fields held
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_valid        <= 1'b0;
         out_pc           <= '0;
         out_rs1          <= '0;
         out_rs2          <= '0;
         out_rd           <= '0;
         out_imm          <= '0;
         out_alu_op       <= ALU_NOP;
         out_alu_src_imm  <= 1'b0;
         out_alu_src_pc   <= 1'b0;
         out_mem_op       <= MEM_NOP;
         out_mem_size     <= SIZE_BYTE;
         out_mem_unsigned <= 1'b0;
         out_reg_we       <= 1'b0;
         out_illegal      <= 1'b0;
      end else if (flush) begin
         out_valid <= 1'b0;
      end else if (accept) begin
         out_valid        <= 1'b1;
         out_pc           <= in_pc;
         out_rs1          <= d_rs1;
         out_rs2          <= d_rs2;
         out_rd           <= d_rd;
         out_imm          <= d_imm;
         out_alu_op       <= d_alu;
         out_alu_src_imm  <= d_simm;
         out_alu_src_pc   <= d_spc;
         out_mem_op       <= d_mop;
         out_mem_size     <= d_msz;
         out_mem_unsigned <= d_muns;
         out_reg_we       <= d_we;
         out_illegal      <= d_ill;
      end else if (out_valid && out_ready) begin
         out_valid <= 1'b0;
      end
   end

   // Count load-use stall cycles, sticking at all-ones
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         stall_cnt <= '0;
      end else if (hazard && !flush && (stall_cnt != {CNT_W{1'b1}})) begin
         stall_cnt <= stall_cnt + CNT_W'(1);
      end
   end

endmodule

// File: tb/tb_decode_stage.sv
// tb_decode_stage: directed scoreboard bench for decode_stage.
module tb_decode_stage;

   logic        clk;
   logic        rst_n;
   logic        flush;
   logic        in_valid;
   logic        in_ready;
   logic [31:0] in_inst;
   logic [31:0] in_pc;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] out_pc;
   logic [4:0]  out_rs1, out_rs2, out_rd;
   logic [31:0] out_imm;
   logic [3:0]  out_alu_op;
   logic        out_alu_src_imm, out_alu_src_pc;
   logic [1:0]  out_mem_op, out_mem_size;
   logic        out_mem_unsigned, out_reg_we, out_illegal;
   logic [15:0] stall_cnt;

   typedef struct packed {
      logic [31:0] pc;
      logic [4:0]  rs1;
      logic [4:0]  rs2;
      logic [4:0]  rd;
      logic [31:0] imm;
      logic [3:0]  alu;
      logic        simm;
      logic        spc;
      logic [1:0]  mop;
      logic [1:0]  msz;
      logic        muns;
      logic        we;
      logic        ill;
   } exp_t;

   exp_t sb[$];
   exp_t cur_exp;
   exp_t e;
   int   checks;
   int   failures;

   decode_stage dut (
      .clk              (clk),
      .rst_n            (rst_n),
      .flush            (flush),
      .in_valid         (in_valid),
      .in_ready         (in_ready),
      .in_inst          (in_inst),
      .in_pc            (in_pc),
      .out_valid        (out_valid),
      .out_ready        (out_ready),
      .out_pc           (out_pc),
      .out_rs1          (out_rs1),
      .out_rs2          (out_rs2),
      .out_rd           (out_rd),
      .out_imm          (out_imm),
      .out_alu_op       (out_alu_op),
      .out_alu_src_imm  (out_alu_src_imm),
      .out_alu_src_pc   (out_alu_src_pc),
      .out_mem_op       (out_mem_op),
      .out_mem_size     (out_mem_size),
      .out_mem_unsigned (out_mem_unsigned),
      .out_reg_we       (out_reg_we),
      .out_illegal      (out_illegal),
      .stall_cnt        (stall_cnt)
   );

   // free-running clock
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
      checks++;
      assert (obs === expv)
      else begin
         failures++;
         $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, obs, expv);
      end
   endtask

   task automatic checkOutput(input exp_t x);
      chk("pc", 64'(out_pc), 64'(x.pc));
      chk("rs1", 64'(out_rs1), 64'(x.rs1));
      chk("rs2", 64'(out_rs2), 64'(x.rs2));
      chk("rd", 64'(out_rd), 64'(x.rd));
      chk("imm", 64'(out_imm), 64'(x.imm));
      chk("alu_op", 64'(out_alu_op), 64'(x.alu));
      chk("src_imm", 64'(out_alu_src_imm), 64'(x.simm));
      chk("src_pc", 64'(out_alu_src_pc), 64'(x.spc));
      chk("mem_op", 64'(out_mem_op), 64'(x.mop));
      chk("mem_size", 64'(out_mem_size), 64'(x.msz));
      chk("mem_uns", 64'(out_mem_unsigned), 64'(x.muns));
      chk("reg_we", 64'(out_reg_we), 64'(x.we));
      chk("illegal", 64'(out_illegal), 64'(x.ill));
   endtask

   task automatic checkAllZero(input string tag);
      chk({tag, "_valid"}, 64'(out_valid), 64'd0);
      chk({tag, "_stall"}, 64'(stall_cnt), 64'd0);
      chk({tag, "_pc"}, 64'(out_pc), 64'd0);
      chk({tag, "_regs"}, 64'({out_rs1, out_rs2, out_rd}), 64'd0);
      chk({tag, "_imm"}, 64'(out_imm), 64'd0);
      chk({tag, "_ctrl"}, 64'({out_alu_op, out_alu_src_imm, out_alu_src_pc, out_mem_op,
                               out_mem_size, out_mem_unsigned, out_reg_we, out_illegal}), 64'd0);
   endtask

   // drive one set of inputs shortly after the rising edge and let them settle
   task automatic applyStimulus(input logic v, input logic [31:0] inst, input logic [31:0] pc,
                                input exp_t x);
      in_valid = v;
      in_inst  = inst;
      in_pc    = pc;
      cur_exp  = x;
      #1;
   endtask

   // scoreboard work at the falling edge, then advance to just after the next rising edge
   task automatic step();
      @(negedge clk);
      chk("sb_depth", 64'(sb.size()), out_valid ? 64'd1 : 64'd0);
      if (out_valid && sb.size() > 0) begin
         checkOutput(sb[0]);
         if (out_ready || flush) void'(sb.pop_front());
      end
      if (in_valid && in_ready) sb.push_back(cur_exp);
      @(posedge clk);
      #1;
   endtask

   initial begin
      checks    = 0;
      failures  = 0;
      rst_n     = 1'b0;
      flush     = 1'b0;
      in_valid  = 1'b0;
      in_inst   = 32'd0;
      in_pc     = 32'd0;
      out_ready = 1'b1;
      e         = '0;
      cur_exp   = '0;

      #2;
      checkAllZero("reset");
      @(posedge clk);
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      #1;
      chk("reset_ready", 64'(in_ready), 64'd1);

      $display("[TB] ADDI x5,x1,-3");
      e = '0; e.pc = 32'h1000; e.rs1 = 5'd1; e.rd = 5'd5; e.imm = 32'hFFFF_FFFD;
      e.alu = 4'd1; e.simm = 1'b1; e.we = 1'b1;
      applyStimulus(1'b1, 32'hFFD0_8293, 32'h1000, e);
      chk("addi_ready", 64'(in_ready), 64'd1);
      step();
      applyStimulus(1'b0, 32'd0, 32'd0, e);
      chk("addi_valid", 64'(out_valid), 64'd1);
      step();

      $display("[TB] load-use LW x6,8(x2) then ADD x7,x6,x3");
      e = '0; e.pc = 32'h1004; e.rs1 = 5'd2; e.rd = 5'd6; e.imm = 32'd8;
      e.alu = 4'd1; e.simm = 1'b1; e.mop = 2'd1; e.msz = 2'd2; e.we = 1'b1;
      applyStimulus(1'b1, 32'h0081_2303, 32'h1004, e);
      step();
      e = '0; e.pc = 32'h1008; e.rs1 = 5'd6; e.rs2 = 5'd3; e.rd = 5'd7;
      e.alu = 4'd1; e.we = 1'b1;
      applyStimulus(1'b1, 32'h0033_03B3, 32'h1008, e);
      chk("lu_load_valid", 64'(out_valid), 64'd1);
      chk("lu_ready_low", 64'(in_ready), 64'd0);
      step();
      chk("lu_bubble", 64'(out_valid), 64'd0);
      chk("lu_stall_cnt", 64'(stall_cnt), 64'd1);
      chk("lu_ready_high", 64'(in_ready), 64'd1);
      step();

      $display("[TB] SB x4,-1(x2) and SUB x8,x1,x2");
      e = '0; e.pc = 32'h100C; e.rs1 = 5'd2; e.rs2 = 5'd4; e.imm = 32'hFFFF_FFFF;
      e.alu = 4'd1; e.simm = 1'b1; e.mop = 2'd2; e.msz = 2'd0;
      applyStimulus(1'b1, 32'hFE41_0FA3, 32'h100C, e);
      chk("add_issued", 64'(out_valid), 64'd1);
      step();
      e = '0; e.pc = 32'h1010; e.rs1 = 5'd1; e.rs2 = 5'd2; e.rd = 5'd8;
      e.alu = 4'd2; e.we = 1'b1;
      applyStimulus(1'b1, 32'h4020_8433, 32'h1010, e);
      step();
      applyStimulus(1'b0, 32'd0, 32'd0, e);
      step();
      step();

      $display("[TB] LUI x9,0x12345 held under backpressure");
      out_ready = 1'b0;
      e = '0; e.pc = 32'h2000; e.rd = 5'd9; e.imm = 32'h1234_5000;
      e.alu = 4'd11; e.simm = 1'b1; e.we = 1'b1;
      applyStimulus(1'b1, 32'h1234_54B7, 32'h2000, e);
      step();
      e = '0; e.pc = 32'h2004; e.rd = 5'd10; e.imm = 32'h8000_0000;
      e.alu = 4'd1; e.simm = 1'b1; e.spc = 1'b1; e.we = 1'b1;
      applyStimulus(1'b1, 32'h8000_0517, 32'h2004, e);
      for (int i = 0; i < 3; i++) begin
         chk("hold_ready", 64'(in_ready), 64'd0);
         chk("hold_valid", 64'(out_valid), 64'd1);
         step();
      end
      out_ready = 1'b1;
      #1;
      chk("release_ready", 64'(in_ready), 64'd1);
      step();
      applyStimulus(1'b0, 32'd0, 32'd0, e);
      step();

      $display("[TB] illegal opcode 0x7F and SRAI with funct7=0000001");
      e = '0; e.pc = 32'h3000; e.ill = 1'b1;
      applyStimulus(1'b1, 32'hFFFF_FFFF, 32'h3000, e);
      step();
      e = '0; e.pc = 32'h3004; e.ill = 1'b1;
      applyStimulus(1'b1, 32'h0230_D293, 32'h3004, e);
      step();
      applyStimulus(1'b0, 32'd0, 32'd0, e);
      step();

      $display("[TB] flush with a held output");
      out_ready = 1'b0;
      e = '0; e.pc = 32'h4000; e.rs1 = 5'd1; e.rd = 5'd5; e.imm = 32'hFFFF_FFFD;
      e.alu = 4'd1; e.simm = 1'b1; e.we = 1'b1;
      applyStimulus(1'b1, 32'hFFD0_8293, 32'h4000, e);
      step();
      flush = 1'b1;
      e.pc = 32'h4004;
      applyStimulus(1'b1, 32'hFFD0_8293, 32'h4004, e);
      chk("flush_ready", 64'(in_ready), 64'd0);
      step();
      flush = 1'b0;
      applyStimulus(1'b0, 32'd0, 32'd0, e);
      chk("flush_valid", 64'(out_valid), 64'd0);
      chk("flush_sb", 64'(sb.size()), 64'd0);
      out_ready = 1'b1;
      step();

      $display("[TB] reset during a held transfer");
      out_ready = 1'b0;
      e = '0; e.pc = 32'h5000; e.rs1 = 5'd1; e.rd = 5'd5; e.imm = 32'hFFFF_FFFD;
      e.alu = 4'd1; e.simm = 1'b1; e.we = 1'b1;
      applyStimulus(1'b1, 32'hFFD0_8293, 32'h5000, e);
      step();
      chk("pre_rst_valid", 64'(out_valid), 64'd1);
      rst_n = 1'b0;
      #1;
      checkAllZero("rst_mid");
      sb.delete();
      in_valid  = 1'b0;
      out_ready = 1'b1;
      step();
      rst_n = 1'b1;
      #1;
      chk("rst_release_ready", 64'(in_ready), 64'd1);
      step();
      chk("sb_drained", 64'(sb.size()), 64'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/decode_stage.md
Name: decode_stage

Overview:
- Registered, handshaked instruction decode stage. Sits between the IF_ID register and the execute stage, replacing the combinational decoder/control pair.
- Decodes the RV32I integer subset: OP-IMM, OP, LOAD, STORE, LUI and AUIPC. Emits register addresses, an extended immediate, ALU and memory control.
- Inserts a one-cycle bubble on a load-use hazard, supports synchronous flush, and counts hazard stall cycles.

Parameters:
- XLEN, 32, datapath/immediate/PC width (>=32); immediates sign-extend to XLEN.
- ALUOP_W, 4, width of out_alu_op.
- CNT_W, 16, width of the saturating stall counter.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- flush  in  1  synchronous kill of held and incoming instruction.
- in_valid  in  1  upstream instruction valid.
- in_ready  out  1  stage accepts in_inst/in_pc this cycle.
- in_inst  in  32  instruction word.
- in_pc  in  XLEN  instruction PC.
- out_valid  out  1  decoded bundle valid.
- out_ready  in  1  downstream accepts bundle.
- out_pc  out  XLEN  registered PC.
- out_rs1, out_rs2, out_rd  out  5 each  register addresses; 0 when unused.
- out_imm  out  XLEN  extended immediate.
- out_alu_op  out  ALUOP_W  0 NOP, 1 ADD, 2 SUB, 3 SLL, 4 SLT, 5 SLTU, 6 XOR, 7 SRL, 8 SRA, 9 OR, 10 AND, 11 PASSB.
- out_alu_src_imm  out  1  operand B = imm.
- out_alu_src_pc  out  1  operand A = pc.
- out_mem_op  out  2  0 NOP, 1 READ, 2 WRITE.
- out_mem_size  out  2  0 byte, 1 half, 2 word.
- out_mem_unsigned  out  1  zero-extend load data.
- out_reg_we  out  1  register write enable.
- out_illegal  out  1  undecodable instruction.
- stall_cnt  out  CNT_W  saturating hazard stall count.

Behaviour:
- Reset (async, rst_n=0): all outputs 0, including out_valid and stall_cnt. First update after release is on the first clk edge.
- Output register: loads on a transfer (in_valid && in_ready). Holds all fields while out_valid && !out_ready. Bubble: out_valid<=0 when the output transfers (out_valid && out_ready) and nothing is accepted; fields then hold their last values.
- hazard = in_valid && out_valid && out_mem_op==READ && out_rd!=0 && (in uses rs1 && in.rs1==out_rd || in uses rs2 && in.rs2==out_rd).
- in_ready = !flush && !hazard && (!out_valid || out_ready). Latency is 1 cycle.
- Load-use: a dependent instruction directly behind a load produces exactly one bubble cycle, provided out_ready=1.
- Flush: out_valid<=0 next edge, has priority over everything, and in_ready=0 in that cycle.
- stall_cnt: +1 each cycle with hazard && !flush, saturates at all-ones.
- Decode by opcode:
  - OP-IMM (0010011): rs1; I-imm, sign-extended; alu_src_imm=1.
    - func3 map: ADDI→ADD, SLTI→SLT, SLTIU→SLTU, XORI→XOR, ORI→OR, ANDI→AND.
    - SLLI, funct7=0 → SLL. SRLI, funct7=0 → SRL. SRAI, funct7=0100000 → SRA. Shift imm = zero-extended inst[24:20].
  - OP (0110011): rs1, rs2; imm=0; funct7=0 gives ADD/SLL/SLT/SLTU/XOR/SRL/OR/AND by func3; funct7=0100000 gives SUB (func3 0) or SRA (func3 5).
  - LOAD (0000011): rs1; I-imm; ADD; src_imm=1; mem READ. func3 0/1/2/4/5 = LB/LH/LW/LBU/LHU, setting size and unsigned.
  - STORE (0100011): rs1, rs2; S-imm {inst[31:25],inst[11:7]} sign-extended; ADD; src_imm=1; mem WRITE; size from func3 0/1/2; out_rd=0.
  - LUI (0110111): imm={inst[31:12],12'b0} sign-extended; PASSB; src_imm=1.
  - AUIPC (0010111): same imm; ADD; src_imm=1; src_pc=1.
- out_reg_we=1 for OP-IMM, OP, LOAD, LUI, AUIPC when rd!=0; otherwise 0.
- Illegal: any other opcode, funct7 or func3 combination not listed above. Result: out_illegal=1, alu NOP, mem NOP, reg_we=0, rs/rd/imm=0, still out_valid=1 and passes through the handshake.

Test Plan:
- Reset: rst_n=0 mid-transfer → all outputs 0 immediately; after release, in_ready=1.
- ADDI x5,x1,-3 (0xFFD08293) → next cycle out_valid=1, rs1=1, rd=5, imm=0xFFFFFFFD, alu_op=1, src_imm=1, reg_we=1.
- LW x6,8(x2) then ADD x7,x6,x3 back-to-back, out_ready=1 → one cycle in_ready=0, out_valid=0 bubble, stall_cnt=1; ADD issues the following cycle.
- SB x4,-1(x2) → mem_op=2, size=0, imm=0xFFFFFFFF, rd=0, reg_we=0. SUB with funct7=0100000 → alu_op=2.
- out_ready=0 for 3 cycles holding LUI x9,0x12345 → fields stable, in_ready=0, imm=0x12345000, alu_op=11.
- Opcode 0x7F, and SRAI with funct7=0000001 → out_illegal=1, reg_we=0. Flush asserted with a valid output → out_valid=0 next edge and no input accepted.
